demux_rr_ctrl: RTL and testbench

- Round-robin scheduler that feeds one valid/ready input stream into a 1-to-8 demultiplexer.
- Each accepted word goes to exactly one of 8 output channels. Channels are chosen in circular order, and only channels enabled in chan_mask are used.
- Output is a one-word register stage. It drives a shared data bus, a 3-bit select and one-hot per-channel valids.
- Sits between a single producer and eight downstream consumers; it is the sequencer for the existing 1x8 demux datapath.

---
 rtl/demux_rr_pkg.sv | 17 +
 rtl/demux_rr_pick.sv | 31 +++
 rtl/demux_rr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_demux_rr_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_rr_pkg.sv
// Shared constants for the round-robin 1x8 demux sequencer: channel count,
// select width, FSM encoding and a one-hot helper.
package demux_rr_pkg;

   localparam int NCH  = 8;
   localparam int SELW = 3;

   // Two-state holding FSM: EMPTY has no word, FULL holds one word.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Build a one-hot channel vector from a channel index.
   function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] idx);
      return NCH'(1) << idx;
   endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Combinational circular priority picker: returns the first set mask bit
// found searching upward from start (wrapping 7->0), optionally skipping
// one excluded index.
module demux_rr_pick
   import demux_rr_pkg::*;
(
   input  logic [NCH-1:0]  mask,
   input  logic [SELW-1:0] start,
   input  logic            excl_en,
   input  logic [SELW-1:0] excl_idx,
   output logic [SELW-1:0] idx,
   output logic            found
);

   logic [SELW-1:0] cand;

   // Walk all channels once starting at 'start'; the first eligible one wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = start + SELW'(i);
         if (!found && mask[cand] && !(excl_en && (cand == excl_idx))) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_rr_ctrl.sv
// Round-robin sequencer for a 1x8 demux: accepts one valid/ready stream,
// holds one word in an output register and steers it to the next enabled
// channel in circular order.
// Optional build macro DEMUX_RR_STALL_SKIP_EN: a word stuck for STALL_LIMIT
// cycles on a non-ready channel is redirected to the next enabled channel.
module demux_rr_ctrl
   import demux_rr_pkg::*;
#(
   parameter int DW          = 8,
   parameter int STALL_LIMIT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [NCH-1:0]  chan_mask,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            in_ready,
   output logic [DW-1:0]   out_data,
   output logic [SELW-1:0] out_sel,
   output logic [NCH-1:0]  out_valid,
   input  logic [NCH-1:0]  out_ready,
   output logic            busy,
   output logic            frame_done
);

   if (STALL_LIMIT < 1) begin : g_bad_limit
      $error("demux_rr_ctrl: STALL_LIMIT must be at least 1");
   end

   logic [0:0]      state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [DW-1:0]   data_q, data_d;
   logic [NCH-1:0]  valid_q, valid_d;
   logic            frame_q, frame_d;

   logic [SELW-1:0] pick_idx;
   logic            pick_found;
   logic [SELW-1:0] hi_idx;
   logic            xfer_out;
   logic            accept;
   logic            redirect;
   logic [SELW-1:0] alt_idx;

   // Next channel for a fresh word, searching from the round-robin pointer.
   demux_rr_pick u_pick (
      .mask     (chan_mask),
      .start    (ptr_q),
      .excl_en  (1'b0),
      .excl_idx ('0),
      .idx      (pick_idx),
      .found    (pick_found)
   );

   assign xfer_out = (state_q == ST_FULL) && out_ready[sel_q];
   // pick_found is equivalent to a non-empty mask; in_valid never feeds in_ready.
   assign in_ready = en && pick_found && ((state_q == ST_EMPTY) || xfer_out);
   assign accept   = in_valid && in_ready;

   // Highest enabled channel marks the end of a frame.
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (chan_mask[i]) hi_idx = SELW'(i);
      end
   end

`ifdef DEMUX_RR_STALL_SKIP_EN
   localparam int CW = $clog2(STALL_LIMIT + 1);

   logic [CW-1:0] stall_q, stall_d;
   logic          stalled;
   logic          at_limit;
   logic          alt_found;

   // Alternative channel for a stuck word: any enabled channel but the current one.
   demux_rr_pick u_alt_pick (
      .mask     (chan_mask),
      .start    (ptr_q),
      .excl_en  (1'b1),
      .excl_idx (sel_q),
      .idx      (alt_idx),
      .found    (alt_found)
   );

   assign stalled  = (state_q == ST_FULL) && !out_ready[sel_q];
   assign at_limit = (stall_q >= CW'(STALL_LIMIT - 1));
   assign redirect = stalled && at_limit && alt_found;

   // Count consecutive stalled cycles; saturate when there is nowhere to go.
   always_comb begin
      stall_d = stall_q;
      if (accept || xfer_out) begin
         stall_d = '0;
      end else if (stalled) begin
         if (at_limit) stall_d = alt_found ? '0 : CW'(STALL_LIMIT);
         else          stall_d = stall_q + 1'b1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end
`else
   assign redirect = 1'b0;
   assign alt_idx  = '0;
`endif

   // Load, drain or redirect the held word and advance the pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      frame_d = xfer_out && (sel_q >= hi_idx);
      if (accept) begin
         state_d = ST_FULL;
         data_d  = in_data;
         sel_d   = pick_idx;
         valid_d = onehot(pick_idx);
         ptr_d   = pick_idx + 1'b1;
      end else if (xfer_out) begin
         state_d = ST_EMPTY;
         valid_d = '0;
      end else if (redirect) begin
         sel_d   = alt_idx;
         valid_d = onehot(alt_idx);
         ptr_d   = alt_idx + 1'b1;
      end
   end

   // State registers; reset discards any held word at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         frame_q <= frame_d;
      end
   end

   assign out_data   = data_q;
   assign out_sel    = sel_q;
   assign out_valid  = valid_q;
   assign busy       = (state_q == ST_FULL);
   assign frame_done = frame_q;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Self-checking bench for demux_rr_ctrl: table-driven streaming vectors plus
// hand-written backpressure, empty-mask, stall and reset sequences.
module tb_demux_rr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [7:0] chan_mask = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready;
   logic [7:0] out_data;
   logic [2:0] out_sel;
   logic [7:0] out_valid;
   logic [7:0] out_ready = '0;
   logic       busy;
   logic       frame_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   demux_rr_ctrl #(.DW(8), .STALL_LIMIT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .chan_mask  (chan_mask),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   typedef struct {
      logic       vld;
      logic [7:0] data;
      logic [7:0] mask;
      logic [7:0] rdy;
      logic       exp_irdy;
      logic [7:0] exp_valid;
      logic [7:0] exp_data;
      logic       exp_frame;
      logic       exp_busy;
   } vec_t;

   vec_t vec [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Streaming through all channels, then a sparse mask (bits 2,5,7).
      vec[0]  = '{1'b1, 8'h10, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'h10, 1'b0, 1'b1};
      vec[1]  = '{1'b1, 8'h11, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h11, 1'b0, 1'b1};
      vec[2]  = '{1'b1, 8'h12, 8'hFF, 8'hFF, 1'b1, 8'h04, 8'h12, 1'b0, 1'b1};
      vec[3]  = '{1'b1, 8'h13, 8'hFF, 8'hFF, 1'b1, 8'h08, 8'h13, 1'b0, 1'b1};
      vec[4]  = '{1'b1, 8'h14, 8'hFF, 8'hFF, 1'b1, 8'h10, 8'h14, 1'b0, 1'b1};
      vec[5]  = '{1'b1, 8'h15, 8'hFF, 8'hFF, 1'b1, 8'h20, 8'h15, 1'b0, 1'b1};
      vec[6]  = '{1'b1, 8'h16, 8'hFF, 8'hFF, 1'b1, 8'h40, 8'h16, 1'b0, 1'b1};
      vec[7]  = '{1'b1, 8'h17, 8'hFF, 8'hFF, 1'b1, 8'h80, 8'h17, 1'b0, 1'b1};
      vec[8]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h17, 1'b1, 1'b0};
      vec[9]  = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h17, 1'b0, 1'b0};
      vec[10] = '{1'b1, 8'h20, 8'hA4, 8'hFF, 1'b1, 8'h04, 8'h20, 1'b0, 1'b1};
      vec[11] = '{1'b1, 8'h21, 8'hA4, 8'hFF, 1'b1, 8'h20, 8'h21, 1'b0, 1'b1};
      vec[12] = '{1'b1, 8'h22, 8'hA4, 8'hFF, 1'b1, 8'h80, 8'h22, 1'b0, 1'b1};
      vec[13] = '{1'b1, 8'h23, 8'hA4, 8'hFF, 1'b1, 8'h04, 8'h23, 1'b1, 1'b1};
      vec[14] = '{1'b1, 8'h24, 8'hA4, 8'hFF, 1'b1, 8'h20, 8'h24, 1'b0, 1'b1};
      vec[15] = '{1'b1, 8'h25, 8'hA4, 8'hFF, 1'b1, 8'h80, 8'h25, 1'b0, 1'b1};
      vec[16] = '{1'b0, 8'h00, 8'hA4, 8'hFF, 1'b1, 8'h00, 8'h25, 1'b1, 1'b0};
      vec[17] = '{1'b0, 8'h00, 8'hA4, 8'hFF, 1'b1, 8'h00, 8'h25, 1'b0, 1'b0};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'h00);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_out_sel", 32'(out_sel), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      en = 1'b1;
      tick();

      // Table-driven streaming vectors
      for (int i = 0; i < 18; i++) begin
         in_valid  = vec[i].vld;
         in_data   = vec[i].data;
         chan_mask = vec[i].mask;
         out_ready = vec[i].rdy;
         #1;
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].exp_irdy));
         tick();
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].exp_valid));
         check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vec[i].exp_data));
         check($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(vec[i].exp_frame));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
         $display("vec %0d: valid=%02h data=%02h frame=%0d busy=%0d", i, out_valid, out_data, frame_done, busy);
      end

      // Backpressure on channel 1, then same-cycle drain and reload
      chan_mask = 8'hFF;
      out_ready = 8'hFD;
      in_valid  = 1'b1;
      in_data   = 8'hA0;
      tick();
      check("bp_first_valid", 32'(out_valid), 32'h01);
      in_data = 8'hA1;
      tick();
      check("bp_held_valid", 32'(out_valid), 32'h02);
      check("bp_held_sel", 32'(out_sel), 32'h1);
      in_data = 8'hA2;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
         check("bp_data_stable", 32'(out_data), 32'hA1);
         check("bp_valid_stable", 32'(out_valid), 32'h02);
         $display("bp cycle %0d: in_ready=%0d data=%02h", c, in_ready, out_data);
      end
      out_ready = 8'hFF;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("bp_next_valid", 32'(out_valid), 32'h04);
      check("bp_next_data", 32'(out_data), 32'hA2);
      in_valid = 1'b0;
      tick();
      check("bp_drained", 32'(busy), 32'h0);

      // Empty mask blocks acceptance; enabling channel 4 delivers the word
      chan_mask = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      for (int c = 0; c < 20; c++) begin
         #1;
         check("mask0_in_ready", 32'(in_ready), 32'h0);
         tick();
      end
      check("mask0_not_busy", 32'(busy), 32'h0);
      chan_mask = 8'h10;
      #1;
      check("mask10_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("mask10_valid", 32'(out_valid), 32'h10);
      check("mask10_sel", 32'(out_sel), 32'h4);
      check("mask10_data", 32'(out_data), 32'h77);
      $display("mask0 test: valid=%02h sel=%0d data=%02h", out_valid, out_sel, out_data);
      in_valid = 1'b0;
      tick();
      check("mask10_frame", 32'(frame_done), 32'h1);

      // Stuck word on channel 0 with mask 03
      chan_mask = 8'h03;
      out_ready = 8'hFE;
      in_valid  = 1'b1;
      in_data   = 8'h88;
      tick();
      in_valid = 1'b0;
      check("stall_load_valid", 32'(out_valid), 32'h01);
`ifdef DEMUX_RR_STALL_SKIP_EN
      for (int c = 0; c < 3; c++) tick();
      check("stall_pre_sel", 32'(out_sel), 32'h0);
      tick();
      check("stall_redir_sel", 32'(out_sel), 32'h1);
      check("stall_redir_valid", 32'(out_valid), 32'h02);
      check("stall_redir_data", 32'(out_data), 32'h88);
`else
      for (int c = 0; c < 10; c++) tick();
      check("stall_wait_sel", 32'(out_sel), 32'h0);
      check("stall_wait_valid", 32'(out_valid), 32'h01);
      check("stall_wait_data", 32'(out_data), 32'h88);
`endif
      $display("stall test: valid=%02h sel=%0d data=%02h", out_valid, out_sel, out_data);
      out_ready = 8'hFF;
      tick();
      check("stall_drained", 32'(busy), 32'h0);

      // Reset while a word is held on channel 3
      chan_mask = 8'h08;
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      tick();
      in_valid = 1'b0;
      check("rstmid_held_valid", 32'(out_valid), 32'h08);
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", 32'(out_valid), 32'h00);
      check("rstmid_busy", 32'(busy), 32'h0);
      tick();
      rst_n     = 1'b1;
      chan_mask = 8'hFF;
      out_ready = 8'hFF;
      in_valid  = 1'b1;
      in_data   = 8'h66;
      tick();
      in_valid = 1'b0;
      check("rstmid_first_valid", 32'(out_valid), 32'h01);
      check("rstmid_first_sel", 32'(out_sel), 32'h0);
      check("rstmid_first_data", 32'(out_data), 32'h66);
      $display("post-reset word: valid=%02h sel=%0d data=%02h", out_valid, out_sel, out_data);
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
